// File: rtl/ste_engine_pkg.sv
// ste_engine_pkg: shared config-target encoding and vector helpers for the STE array engine
package ste_engine_pkg;
    typedef enum logic [2:0] {
        MATCH     = 3'd0,
        ADJ       = 3'd1,
        START_SOD = 3'd2,
        START_ALL = 3'd3,
        REPORT    = 3'd4
    } cfg_target_e;
    localparam int STE_MAX = 64;
    typedef logic [STE_MAX-1:0] ste_vec_t;
    function automatic logic cfg_target_ok(input logic [2:0] t);
        return t <= REPORT;
    endfunction
endpackage

// File: rtl/ste_array_engine_match_table.sv
// ste_match_table: 2^SYM_W x N_STE symbol-match flop array, sync write, comb read
module ste_match_table
    import ste_engine_pkg::*;
#(
    parameter int N_STE = 16,
    parameter int SYM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [SYM_W-1:0] waddr,
    input  logic [N_STE-1:0] wdata,
    input  logic [SYM_W-1:0] raddr,
    output logic [N_STE-1:0] rdata
);
    localparam int ROWS = 1 << SYM_W;
    logic [N_STE-1:0] mem_q [ROWS];
    logic [N_STE-1:0] mem_d [ROWS];
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end
    always_ff @(posedge clk) begin
        if (reset) mem_q <= '{default: '0};
        else mem_q <= mem_d;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/ste_array_engine.sv
// ste_array_engine: runtime-programmable homogeneous STE automaton with buffered report output
module ste_array_engine
    import ste_engine_pkg::*;
#(
    parameter int N_STE = 16,
    parameter int SYM_W = 8,
    parameter int OFF_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             flush,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_target,
    input  logic [SYM_W-1:0] cfg_addr,
    input  logic [N_STE-1:0] cfg_wdata,
    output logic             cfg_err,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    output logic             rep_valid,
    output logic [N_STE-1:0] rep_vec,
    output logic [OFF_W-1:0] rep_offset,
    input  logic             rep_ready,
    output logic [N_STE-1:0] active,
    output logic [CNT_W-1:0] rep_count
);
    localparam int AW = $clog2(N_STE);
    logic [N_STE-1:0] adj_q [N_STE];
    logic [N_STE-1:0] adj_d [N_STE];
    logic [N_STE-1:0] start_sod_q, start_sod_d, start_all_q, start_all_d, report_mask_q, report_mask_d;
    logic [N_STE-1:0] active_q, active_d, rep_vec_q, rep_vec_d;
    logic             sod_q, sod_d, rep_valid_q, rep_valid_d, cfg_err_q, cfg_err_d;
    logic [OFF_W-1:0] off_q, off_d, rep_offset_q, rep_offset_d;
    logic [CNT_W-1:0] rep_count_q, rep_count_d;
    logic [N_STE-1:0] match_row, en, active_next, rep_hit_vec;
    logic             accept, cfg_ok, cfg_bad_addr;
    assign cfg_bad_addr = (cfg_target == ADJ) && (int'(cfg_addr) >= N_STE);
    assign cfg_ok       = cfg_we & ~run & cfg_target_ok(cfg_target) & ~cfg_bad_addr;
    ste_match_table #(.N_STE(N_STE), .SYM_W(SYM_W)) u_match (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_ok && cfg_target == MATCH),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (sym_data),
        .rdata (match_row)
    );
    for (genvar i = 0; i < N_STE; i++) begin : g_en
        logic [N_STE-1:0] col;
        for (genvar j = 0; j < N_STE; j++) begin : g_col
            assign col[j] = adj_q[j][i];
        end
        assign en[i] = (|(active_q & col)) | (sod_q & start_sod_q[i]) | start_all_q[i];
    end
    assign active_next = en & match_row;
    assign rep_hit_vec = active_next & report_mask_q;
    assign sym_ready   = run & ~flush & (~rep_valid_q | rep_ready);
    assign accept      = sym_valid & sym_ready;
    always_comb begin
        adj_d         = adj_q;
        if (cfg_ok && cfg_target == ADJ) adj_d[cfg_addr[AW-1:0]] = cfg_wdata;
        start_sod_d   = (cfg_ok && cfg_target == START_SOD) ? cfg_wdata : start_sod_q;
        start_all_d   = (cfg_ok && cfg_target == START_ALL) ? cfg_wdata : start_all_q;
        report_mask_d = (cfg_ok && cfg_target == REPORT) ? cfg_wdata : report_mask_q;
        cfg_err_d     = cfg_err_q | (cfg_we & ~cfg_ok);
        active_d      = active_q;
        sod_d         = sod_q;
        off_d         = off_q;
        rep_valid_d   = rep_valid_q & ~rep_ready;
        rep_vec_d     = rep_vec_q;
        rep_offset_d  = rep_offset_q;
        rep_count_d   = rep_count_q;
        if (flush) begin
            active_d    = '0;
            sod_d       = 1'b1;
            off_d       = '0;
            rep_valid_d = 1'b0;
        end else if (accept) begin
            active_d = active_next;
            sod_d    = 1'b0;
            off_d    = off_q + OFF_W'(1);
            if (|rep_hit_vec) begin
                rep_valid_d  = 1'b1;
                rep_vec_d    = rep_hit_vec;
                rep_offset_d = off_q;
                rep_count_d  = &rep_count_q ? rep_count_q : rep_count_q + CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            adj_q         <= '{default: '0};
            start_sod_q   <= '0;
            start_all_q   <= '0;
            report_mask_q <= '0;
            cfg_err_q     <= 1'b0;
            active_q      <= '0;
            sod_q         <= 1'b1;
            off_q         <= '0;
            rep_valid_q   <= 1'b0;
            rep_vec_q     <= '0;
            rep_offset_q  <= '0;
            rep_count_q   <= '0;
        end else begin
            adj_q         <= adj_d;
            start_sod_q   <= start_sod_d;
            start_all_q   <= start_all_d;
            report_mask_q <= report_mask_d;
            cfg_err_q     <= cfg_err_d;
            active_q      <= active_d;
            sod_q         <= sod_d;
            off_q         <= off_d;
            rep_valid_q   <= rep_valid_d;
            rep_vec_q     <= rep_vec_d;
            rep_offset_q  <= rep_offset_d;
            rep_count_q   <= rep_count_d;
        end
    end
    assign cfg_err    = cfg_err_q;
    assign rep_valid  = rep_valid_q;
    assign rep_vec    = rep_vec_q;
    assign rep_offset = rep_offset_q;
    assign active     = active_q;
    assign rep_count  = rep_count_q;
endmodule

// File: tb/tb_ste_array_engine.sv
// tb_ste_array_engine: directed tables, corner sequences and randomized model comparison
module tb_ste_array_engine;
    localparam int N = 16, SW = 8, OW = 4, CW = 4;
    logic          clk = 1'b0;
    logic          reset, run, flush, cfg_we, cfg_err, sym_valid, sym_ready, rep_valid, rep_ready;
    logic [2:0]    cfg_target;
    logic [SW-1:0] cfg_addr, sym_data;
    logic [N-1:0]  cfg_wdata, rep_vec, active;
    logic [OW-1:0] rep_offset;
    logic [CW-1:0] rep_count;
    always #5 clk = ~clk;
    ste_array_engine #(.N_STE(N), .SYM_W(SW), .OFF_W(OW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .flush      (flush),
        .cfg_we     (cfg_we),
        .cfg_target (cfg_target),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_err    (cfg_err),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .rep_valid  (rep_valid),
        .rep_vec    (rep_vec),
        .rep_offset (rep_offset),
        .rep_ready  (rep_ready),
        .active     (active),
        .rep_count  (rep_count)
    );
    int errors = 0, checks = 0;
    logic [N-1:0] m_match [256];
    logic [N-1:0] m_adj [N];
    logic [N-1:0] m_ssod, m_sall, m_rmask, m_active, m_rvec;
    logic         m_sod, m_rv, m_err, m_rdy;
    int           m_off, m_roff, m_cnt;
    typedef struct {
        logic [7:0]    sym;
        logic [N-1:0]  act;
        logic          rv;
        logic [N-1:0]  rvec;
        logic [OW-1:0] roff;
    } vec_t;
    vec_t vecs [8];
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask
    task automatic mdl_step();
        logic [N-1:0] nxt;
        logic acc, e;
        if (reset) begin
            foreach (m_match[s]) m_match[s] = '0;
            foreach (m_adj[j]) m_adj[j] = '0;
            m_ssod = '0; m_sall = '0; m_rmask = '0; m_active = '0; m_rvec = '0;
            m_sod = 1'b1; m_rv = 1'b0; m_err = 1'b0;
            m_off = 0; m_roff = 0; m_cnt = 0;
            return;
        end
        acc = sym_valid && m_rdy;
        for (int i = 0; i < N; i++) begin
            e = m_sall[i] || (m_sod && m_ssod[i]);
            for (int j = 0; j < N; j++) if (m_active[j] && m_adj[j][i]) e = 1'b1;
            nxt[i] = e && m_match[sym_data][i];
        end
        if (cfg_we) begin
            if (run || cfg_target > 3'd4 || (cfg_target == 3'd1 && int'(cfg_addr) >= N)) m_err = 1'b1;
            else case (cfg_target)
                3'd0: m_match[sym_data == sym_data ? cfg_addr : cfg_addr] = cfg_wdata;
                3'd1: m_adj[int'(cfg_addr)] = cfg_wdata;
                3'd2: m_ssod = cfg_wdata;
                3'd3: m_sall = cfg_wdata;
                default: m_rmask = cfg_wdata;
            endcase
        end
        if (flush) begin
            m_active = '0; m_sod = 1'b1; m_off = 0; m_rv = 1'b0;
        end else begin
            if (rep_ready) m_rv = 1'b0;
            if (acc) begin
                m_active = nxt;
                m_sod = 1'b0;
                if ((nxt & m_rmask) != 0) begin
                    m_rv = 1'b1; m_rvec = nxt & m_rmask; m_roff = m_off;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end
                m_off = (m_off + 1) % (1 << OW);
            end
        end
    endtask
    task automatic tick();
        #1;
        m_rdy = run && !flush && (!m_rv || rep_ready);
        if (!reset) chk("sym_ready_model", 32'(sym_ready), 32'(m_rdy));
        mdl_step();
        @(posedge clk);
        #1;
    endtask
    task automatic cmp_model();
        chk("rnd_active", 32'(active), 32'(m_active));
        chk("rnd_rep_valid", 32'(rep_valid), 32'(m_rv));
        chk("rnd_rep_count", 32'(rep_count), 32'(m_cnt));
        chk("rnd_cfg_err", 32'(cfg_err), 32'(m_err));
        if (m_rv) begin
            chk("rnd_rep_vec", 32'(rep_vec), 32'(m_rvec));
            chk("rnd_rep_offset", 32'(rep_offset), 32'(m_roff));
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
    task automatic cfg_write(input logic [2:0] t, input logic [7:0] a, input logic [N-1:0] d);
        cfg_we = 1'b1; cfg_target = t; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask
    task automatic feed(input logic [7:0] s);
        sym_valid = 1'b1; sym_data = s;
        tick();
    endtask
    task automatic prog_legacy(input logic [N-1:0] rm);
        for (int s = 0; s < 256; s++) begin
            logic [7:0] b;
            b = 8'(s);
            if (b[5:4] < 2'd2) cfg_write(3'd0, b, b[5:4] == 2'd0 ? 16'h1 : 16'h2);
        end
        cfg_write(3'd1, 8'd0, 16'h3);
        cfg_write(3'd2, 8'd0, 16'h1);
        cfg_write(3'd4, 8'd0, rm);
    endtask
    task automatic prog_aa();
        cfg_write(3'd0, 8'hAA, 16'h8);
        cfg_write(3'd3, 8'd0, 16'h8);
        cfg_write(3'd4, 8'd0, 16'h8);
    endtask
    task automatic apply_vec(input int k);
        feed(vecs[k].sym);
        chk($sformatf("vec%0d_active", k), 32'(active), 32'(vecs[k].act));
        chk($sformatf("vec%0d_rep_valid", k), 32'(rep_valid), 32'(vecs[k].rv));
        if (vecs[k].rv) begin
            chk($sformatf("vec%0d_rep_vec", k), 32'(rep_vec), 32'(vecs[k].rvec));
            chk($sformatf("vec%0d_rep_offset", k), 32'(rep_offset), 32'(vecs[k].roff));
        end
    endtask
    initial begin
        vecs[0] = '{8'h00, 16'h0001, 1'b0, 16'h0, 4'd0};
        vecs[1] = '{8'h05, 16'h0001, 1'b0, 16'h0, 4'd0};
        vecs[2] = '{8'h10, 16'h0002, 1'b1, 16'h2, 4'd2};
        vecs[3] = '{8'h30, 16'h0000, 1'b0, 16'h0, 4'd0};
        vecs[4] = '{8'h00, 16'h0000, 1'b0, 16'h0, 4'd0};
        vecs[5] = '{8'hAA, 16'h0008, 1'b1, 16'h8, 4'd1};
        vecs[6] = '{8'h00, 16'h0000, 1'b0, 16'h0, 4'd0};
        vecs[7] = '{8'hAA, 16'h0008, 1'b1, 16'h8, 4'd3};
        reset = 1'b0; run = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_target = '0; cfg_addr = '0;
        cfg_wdata = '0; sym_valid = 1'b0; sym_data = '0; rep_ready = 1'b0;
        do_reset();
        chk("rst_active", 32'(active), 0);
        chk("rst_rep_valid", 32'(rep_valid), 0);
        chk("rst_rep_vec", 32'(rep_vec), 0);
        chk("rst_rep_offset", 32'(rep_offset), 0);
        chk("rst_rep_count", 32'(rep_count), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_sym_ready", 32'(sym_ready), 0);
        prog_legacy(16'h2);
        run = 1'b1; rep_ready = 1'b1;
        for (int k = 0; k < 4; k++) apply_vec(k);
        chk("legacy_rep_count", 32'(rep_count), 1);
        run = 1'b0; sym_valid = 1'b0;
        do_reset();
        prog_aa();
        run = 1'b1;
        for (int k = 4; k < 8; k++) apply_vec(k);
        chk("allstart_rep_count", 32'(rep_count), 2);
        rep_ready = 1'b0; sym_valid = 1'b1; sym_data = 8'h00;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_sym_ready_low", 32'(sym_ready), 0);
            tick();
            chk("bp_rep_valid", 32'(rep_valid), 1);
            chk("bp_rep_vec", 32'(rep_vec), 32'h8);
            chk("bp_rep_offset", 32'(rep_offset), 3);
            chk("bp_active_hold", 32'(active), 32'h8);
        end
        rep_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(sym_ready), 1);
        tick();
        chk("bp_release_active", 32'(active), 0);
        chk("bp_release_rep_valid", 32'(rep_valid), 0);
        feed(8'hAA);
        chk("bp_next_rep_valid", 32'(rep_valid), 1);
        chk("bp_next_rep_offset", 32'(rep_offset), 5);
        sym_valid = 1'b0;
        cfg_write(3'd0, 8'h55, 16'hFFFF);
        chk("cfg_run_err", 32'(cfg_err), 1);
        feed(8'h55);
        chk("cfg_run_table_unchanged", 32'(active), 0);
        run = 1'b0; sym_valid = 1'b0;
        cfg_write(3'd6, 8'd0, 16'hFFFF);
        chk("cfg_t6_err_sticky", 32'(cfg_err), 1);
        do_reset();
        chk("cfg_err_cleared", 32'(cfg_err), 0);
        cfg_write(3'd6, 8'd0, 16'hFFFF);
        chk("cfg_t6_err", 32'(cfg_err), 1);
        do_reset();
        cfg_write(3'd1, 8'd16, 16'h1);
        chk("cfg_adj_oob_err", 32'(cfg_err), 1);
        do_reset();
        cfg_write(3'd1, 8'd15, 16'h1);
        cfg_write(3'd4, 8'd0, 16'h1);
        chk("cfg_legal_no_err", 32'(cfg_err), 0);
        do_reset();
        prog_legacy(16'h3);
        run = 1'b1; rep_ready = 1'b1;
        for (int c = 0; c < 7; c++) feed(8'h00);
        feed(8'h10);
        chk("fl_pre_active", 32'(active), 32'h2);
        chk("fl_pre_rep_valid", 32'(rep_valid), 1);
        chk("fl_pre_rep_offset", 32'(rep_offset), 7);
        rep_ready = 1'b0; flush = 1'b1; sym_valid = 1'b1; sym_data = 8'h00;
        tick();
        flush = 1'b0;
        chk("fl_active", 32'(active), 0);
        chk("fl_rep_valid", 32'(rep_valid), 0);
        rep_ready = 1'b1;
        feed(8'h00);
        chk("fl_sod_refire", 32'(active), 32'h1);
        chk("fl_rep_vec", 32'(rep_vec), 32'h1);
        chk("fl_rep_offset0", 32'(rep_offset), 0);
        chk("fl_rep_count_kept", 32'(rep_count), 9);
        run = 1'b0; sym_valid = 1'b0;
        do_reset();
        prog_aa();
        run = 1'b1;
        for (int c = 0; c < 15; c++) feed(8'h00);
        feed(8'hAA);
        chk("wrap_off15", 32'(rep_offset), 15);
        feed(8'hAA);
        chk("wrap_rep_valid", 32'(rep_valid), 1);
        chk("wrap_off0", 32'(rep_offset), 0);
        run = 1'b0; sym_valid = 1'b0;
        do_reset();
        for (int s = 0; s < 16; s++) cfg_write(3'd0, 8'(s), 16'($urandom));
        for (int j = 0; j < N; j++) cfg_write(3'd1, 8'(j), 16'($urandom & $urandom));
        cfg_write(3'd2, 8'd0, 16'($urandom));
        cfg_write(3'd3, 8'd0, 16'($urandom & $urandom & $urandom));
        cfg_write(3'd4, 8'd0, 16'($urandom));
        for (int c = 0; c < 3000; c++) begin
            run        = $urandom_range(0, 15) != 0;
            flush      = $urandom_range(0, 39) == 0;
            sym_valid  = $urandom_range(0, 9) < 7;
            rep_ready  = $urandom_range(0, 9) < 6;
            sym_data   = 8'($urandom_range(0, 15));
            cfg_we     = (!run && $urandom_range(0, 2) == 0) || $urandom_range(0, 199) == 0;
            cfg_target = 3'($urandom_range(0, 7));
            cfg_addr   = 8'($urandom_range(0, 31));
            cfg_wdata  = 16'($urandom);
            tick();
            cmp_model();
        end
        cfg_we = 1'b0; flush = 1'b0; sym_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ste_array_engine.md
# ste_array_engine

Runtime-programmable homogeneous automaton engine for the runtime-monitor clusters. It replaces the per-property, hard-wired STE netlists with one array of `N_STE` states. The symbol-match table, transition adjacency, start modes and report mask are all loaded through a configuration port. It consumes one symbol per accepted beat and emits registered report beats through a one-entry, back-pressured output buffer.

## Interface
Parameters:
- `N_STE`, 16: number of STEs; minimum 2.
- `SYM_W`, 8: symbol width; the match table has 2^SYM_W rows.
- `OFF_W`, 32: width of the symbol-offset counter.
- `CNT_W`, 16: width of the report-event counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: engine enabled. Config writes are legal only while low.
- `flush` in 1: single-cycle pulse that restarts the stream without touching configuration.
- `cfg_we` in 1: configuration write strobe.
- `cfg_target` in 3: write target.
  - 0 = match row
  - 1 = adjacency row
  - 2 = start-of-data mask
  - 3 = all-input start mask
  - 4 = report mask
- `cfg_addr` in SYM_W: row index. It is the symbol for target 0, the source STE for target 1, and is ignored for targets 2–4.
- `cfg_wdata` in N_STE: row or mask data; bit i corresponds to STE i.
- `cfg_err` out 1: sticky flag, set by an illegal config write.
- `sym_valid` in 1: input symbol valid.
- `sym_data` in SYM_W: input symbol.
- `sym_ready` out 1: engine accepts the symbol this cycle.
- `rep_valid` out 1: report beat valid.
- `rep_vec` out N_STE: STEs that reported.
- `rep_offset` out OFF_W: offset of the symbol that caused the report.
- `rep_ready` in 1: downstream accepts the report beat.
- `active` out N_STE: current active-state vector, for debug.
- `rep_count` out CNT_W: number of report beats generated; saturates at its maximum.

## Operation
- **State equation per accepted symbol s.** For each STE i:
  - `en[i] = OR_j(active[j] & adj[j][i]) | (sod & start_sod[i]) | start_all[i]`
  - `active_next[i] = en[i] & match[s][i]`
- **Start-of-data flag `sod`.** Set by reset or `flush`. Cleared on the first accepted symbol.
- **Accept rule.** `sym_ready = run & ~flush & (~rep_valid | rep_ready)`. A beat is accepted when `sym_valid & sym_ready`. With no accept, `active` holds.
- **Report generation.** On accept, if `active_next & report_mask` is non-zero:
  - `rep_valid` is set, with `rep_vec` = that masked vector and `rep_offset` = the offset counter before increment.
  - `rep_count` increments, saturating.
- **Report clearing.** `rep_valid` clears on `rep_ready` when no new report is produced in the same cycle. If a report is consumed and a new one is produced in the same cycle, the new beat replaces the old one.
- **Offset counter.** Increments on every accept and wraps modulo 2^OFF_W.
- **Configuration writes.**
  - A write applies at the clock edge when `cfg_we & ~run`.
  - A write with `cfg_we & run` is dropped and sets `cfg_err`.
  - Target 1 with `cfg_addr >= N_STE` is dropped and sets `cfg_err`.
  - Targets 5–7 are dropped and set `cfg_err`.
- **Flush.** On `flush`:
  - `active` clears to 0, `sod` is set to 1 and the offset counter clears to 0.
  - A pending report beat is dropped.
  - `rep_count`, `cfg_err` and all tables are retained.
- **Run deassertion.** Dropping `run` mid-stream freezes `active`, the offset counter and `sod`. A pending report beat stays valid until it is consumed.

## Timing
- **Reset values.**
  - Outputs: `active`=0, `rep_valid`=0, `rep_vec`=0, `rep_offset`=0, `rep_count`=0, `cfg_err`=0.
  - Internal: `sod`=1, offset counter=0; match table, adjacency, start masks and report mask all 0.
  - `sym_ready` is combinational and therefore 0 while `run` is low.
- **Latency.** A symbol accepted at edge E updates `active` at E. The resulting report is visible on `rep_valid`/`rep_vec` in the cycle following E, giving one-cycle latency.
- **Config-to-run.** A config write at edge E is effective for a symbol accepted at edge E+1 or later.
- **Throughput.** One symbol per cycle while `rep_ready` is held high.
- **Reset priority.** `reset` has priority over `flush`, which has priority over an accept.
- **Mid-stream reset.** Reset mid-stream clears the tables, so the engine must be reprogrammed afterwards.

## Structure
- **Package `ste_engine_pkg`.** Holds the `cfg_target_e` enum (MATCH, ADJ, START_SOD, START_ALL, REPORT) and the `ste_vec_t` typedef helper.
- **Sub-module `ste_match_table`.** A 2^SYM_W × N_STE flop array with a synchronous write port and a combinational read indexed by `sym_data`.
- **Top level.** Adjacency and masks stay in the top level as flop arrays. The OR-reduction over adjacency is done with a generate loop.

## Test plan
1. **Legacy-property program.** Configure STE0 (start_sod, match `sym[5:4]==0`, self-loop) and STE1 (report, `adj[0]` includes 1, match `sym[5:4]==1`).
   - Stream 0x00, 0x05, 0x10 -> `active` sequence 01, 01, 10.
   - One report beat with `rep_vec`=0x0002 and `rep_offset`=2.
2. **All-input start.** STE3 start_all + report, matching 0xAA only.
   - Stream 0x00, 0xAA, 0x00, 0xAA -> reports at offsets 1 and 3; `rep_count`=2.
3. **Backpressure.** Generate a report, then hold `rep_ready`=0 for 3 cycles.
   - `sym_ready`=0 throughout; the report beat is stable.
   - On release, the next symbol is accepted in that same cycle.
4. **Illegal config.**
   - `cfg_we` with `run`=1 -> the table is unchanged and `cfg_err`=1.
   - `cfg_target`=6 -> `cfg_err` stays 1.
5. **Flush mid-stream.** Flush after offset 7 while `active`≠0 and a report is pending.
   - Next cycle: `active`=0, `rep_valid`=0, `sod`=1.
   - The next symbol takes offset 0 and re-fires start_sod STEs.
6. **Offset wrap.** With OFF_W=4, stream 17 symbols -> the report on the 17th symbol carries `rep_offset`=0.
